// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation modes and FSM states.
// S_GCD is always enumerated; its logic exists only with SEQ_ALU_GCD_EN.
package alu_pkg;

    localparam logic [2:0] ALU_MAX = 3'd0;
    localparam logic [2:0] ALU_MIN = 3'd1;
    localparam logic [2:0] ALU_MOD = 3'd2;
    localparam logic [2:0] ALU_DIV = 3'd3;
    localparam logic [2:0] ALU_GCD = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_GCD  = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// subtract the divisor when it fits and record the quotient bit.
module alu_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] div_ext;
    logic           fits;

    assign shifted = {r[WIDTH-1:0], q[WIDTH-1]};
    assign div_ext = {1'b0, divisor};
    assign fits    = (shifted >= div_ext);

    always_comb begin
        r_next = fits ? (shifted - div_ext) : shifted;
        q_next = {q[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: max/min single-cycle, mod/div via a shared restoring
// divider, optional Euclidean GCD when SEQ_ALU_GCD_EN is defined.
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       alu_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] res_o,
    output logic             valid_o,
    output logic             err_o
);

    alu_state_t       state, state_n;
    logic [WIDTH-1:0] q, q_n;
    logic [WIDTH:0]   r, r_n;
    logic [WIDTH-1:0] div_b, div_b_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             is_mod, is_mod_n;
    logic [WIDTH-1:0] res_n;
    logic             err_n;
    logic             valid_n;

    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] step_q;
    logic             accept;
    logic             last;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    alu_div_step #(.WIDTH(WIDTH)) u_step (
        .r       (r),
        .q       (q),
        .divisor (div_b),
        .r_next  (step_r),
        .q_next  (step_q)
    );

    assign ready_o = (state == S_IDLE);
    assign accept  = start_i & ready_o;
    assign last    = (cnt == CNT_ONE);

    always_comb begin
        state_n  = state;
        q_n      = q;
        r_n      = r;
        div_b_n  = div_b;
        cnt_n    = cnt;
        is_mod_n = is_mod;
        res_n    = res_o;
        err_n    = err_o;
        valid_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (alu_mode_i)
                        ALU_MAX: begin
                            res_n   = (op_a_i > op_b_i) ? op_a_i : op_b_i;
                            err_n   = 1'b0;
                            valid_n = 1'b1;
                        end
                        ALU_MIN: begin
                            res_n   = (op_a_i < op_b_i) ? op_a_i : op_b_i;
                            err_n   = 1'b0;
                            valid_n = 1'b1;
                        end
                        ALU_MOD, ALU_DIV: begin
                            if (op_b_i == '0) begin
                                res_n   = '0;
                                err_n   = 1'b1;
                                valid_n = 1'b1;
                            end else begin
                                q_n      = op_a_i;
                                r_n      = '0;
                                div_b_n  = op_b_i;
                                cnt_n    = CNT_INIT;
                                is_mod_n = (alu_mode_i == ALU_MOD);
                                state_n  = S_DIV;
                            end
                        end
`ifdef SEQ_ALU_GCD_EN
                        ALU_GCD: begin
                            if (op_b_i == '0) begin
                                res_n   = op_a_i;
                                err_n   = 1'b0;
                                valid_n = 1'b1;
                            end else begin
                                q_n     = op_a_i;
                                r_n     = '0;
                                div_b_n = op_b_i;
                                cnt_n   = CNT_INIT;
                                state_n = S_GCD;
                            end
                        end
`endif
                        default: begin
                            res_n   = '0;
                            err_n   = 1'b0;
                            valid_n = 1'b1;
                        end
                    endcase
                end
            end
            S_DIV: begin
                r_n   = step_r;
                q_n   = step_q;
                cnt_n = cnt - CNT_ONE;
                if (last) begin
                    res_n   = is_mod ? step_r[WIDTH-1:0] : step_q;
                    err_n   = 1'b0;
                    valid_n = 1'b1;
                    state_n = S_IDLE;
                end
            end
`ifdef SEQ_ALU_GCD_EN
            S_GCD: begin
                r_n   = step_r;
                q_n   = step_q;
                cnt_n = cnt - CNT_ONE;
                if (last) begin
                    if (step_r == '0) begin
                        res_n   = div_b;
                        err_n   = 1'b0;
                        valid_n = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        // x <- y, y <- x mod y; next mod starts immediately
                        q_n     = div_b;
                        r_n     = '0;
                        div_b_n = step_r[WIDTH-1:0];
                        cnt_n   = CNT_INIT;
                    end
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            q       <= '0;
            r       <= '0;
            div_b   <= '0;
            cnt     <= '0;
            is_mod  <= 1'b0;
            res_o   <= '0;
            err_o   <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            state   <= state_n;
            q       <= q_n;
            r       <= r_n;
            div_b   <= div_b_n;
            cnt     <= cnt_n;
            is_mod  <= is_mod_n;
            res_o   <= res_n;
            err_o   <= err_n;
            valid_o <= valid_n;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed requests push expectations,
// a negedge monitor pops and checks result, error flag and latency.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_i = 1'b0;
    logic [2:0]   alu_mode_i = 3'd0;
    logic [W-1:0] op_a_i = '0;
    logic [W-1:0] op_b_i = '0;
    logic         ready_o;
    logic [W-1:0] res_o;
    logic         valid_o;
    logic         err_o;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .alu_mode_i (alu_mode_i),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .ready_o    (ready_o),
        .res_o      (res_o),
        .valid_o    (valid_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         err;
        int           acc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && valid_o) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(valid_o), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_res"}, 32'(res_o), 32'(e.res));
                check({e.name, "_err"}, 32'(err_o), 32'(e.err));
                check({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    // Waits for ready, presents one request for one edge; acc is the
    // cycle index right after the accepting edge.
    task automatic issue(input string name, input logic [2:0] m,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic ee,
                         input int lat, input bit push, output int acc);
        int w;
        w = 0;
        while (!ready_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!ready_o) begin
            check({name, "_ready_timeout"}, 32'(ready_o), 32'd1);
            acc = -1;
            return;
        end
        start_i    = 1'b1;
        alu_mode_i = m;
        op_a_i     = a;
        op_b_i     = b;
        acc        = cyc + 1;
        if (push) sb.push_back('{name, er, ee, acc, lat});
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    initial begin
        int acc1, acc2, lowc, w;

        repeat (3) @(negedge clk);
        check("rst_res",   32'(res_o),   32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_err",   32'(err_o),   32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        issue("max", ALU_MAX, 16'd7, 16'd300, 16'd300, 1'b0, 0, 1'b1, acc1);
        check("max_ready", 32'(ready_o), 32'd1);
        issue("min", ALU_MIN, 16'd7, 16'd300, 16'd7, 1'b0, 0, 1'b1, acc1);
        issue("min_eq", ALU_MIN, 16'd300, 16'd300, 16'd300, 1'b0, 0, 1'b1, acc1);
        issue("max_ext", ALU_MAX, 16'hFFFF, 16'd0, 16'hFFFF, 1'b0, 0, 1'b1, acc1);
        issue("mode6", 3'd6, 16'd55, 16'd66, 16'd0, 1'b0, 0, 1'b1, acc1);

        issue("mod_busy", ALU_MOD, 16'd1000, 16'd7, 16'd6, 1'b0, 16, 1'b1, acc1);
        lowc = 1;
        w = 0;
        while (!ready_o && w < 100) begin
            start_i    = 1'b1;
            alu_mode_i = 3'(w);
            op_a_i     = 16'(w * 37 + 1);
            op_b_i     = 16'(w + 2);
            @(negedge clk);
            if (!ready_o) lowc++;
            w++;
        end
        start_i = 1'b0;
        check("mod_ready_low", 32'(lowc), 32'd16);

        issue("div", ALU_DIV, 16'd1000, 16'd7, 16'd142, 1'b0, 16, 1'b1, acc1);
        issue("div_max", ALU_DIV, 16'hFFFF, 16'd1, 16'hFFFF, 1'b0, 16, 1'b1, acc1);
        issue("mod_zero", ALU_MOD, 16'd5, 16'd0, 16'd0, 1'b1, 0, 1'b1, acc1);
        issue("div_zero", ALU_DIV, 16'd9, 16'd0, 16'd0, 1'b1, 0, 1'b1, acc1);

`ifdef SEQ_ALU_GCD_EN
        issue("gcd", ALU_GCD, 16'd48, 16'd18, 16'd6, 1'b0, 48, 1'b1, acc1);
        issue("gcd_a0", ALU_GCD, 16'd0, 16'd5, 16'd5, 1'b0, 16, 1'b1, acc1);
        issue("gcd_b0", ALU_GCD, 16'd7, 16'd0, 16'd7, 1'b0, 0, 1'b1, acc1);
`else
        issue("gcd_off", ALU_GCD, 16'd48, 16'd18, 16'd0, 1'b0, 0, 1'b1, acc1);
        issue("gcd_off_b0", ALU_GCD, 16'd7, 16'd0, 16'd0, 1'b0, 0, 1'b1, acc1);
`endif

        issue("b2b_mod", ALU_MOD, 16'd1000, 16'd7, 16'd6, 1'b0, 16, 1'b1, acc1);
        issue("b2b_div", ALU_DIV, 16'd100, 16'd9, 16'd11, 1'b0, 16, 1'b1, acc2);
        check("b2b_accept_cycle", 32'(acc2), 32'(acc1 + 17));

        w = 0;
        while (!ready_o && w < 100) begin
            @(negedge clk);
            w++;
        end
        issue("abort_div", ALU_DIV, 16'd1000, 16'd7, 16'd0, 1'b0, 0, 1'b0, acc1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_res",   32'(res_o),   32'd0);
        check("abort_valid", 32'(valid_o), 32'd0);
        check("abort_err",   32'(err_o),   32'd0);
        check("abort_ready", 32'(ready_o), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (24) @(negedge clk);

        issue("post_rst_mod", ALU_MOD, 16'd100, 16'd9, 16'd1, 1'b0, 16, 1'b1, acc1);

        w = 0;
        while (sb.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() > 0) check("drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised multi-cycle successor to the combinational 16-bit ALU. It supports max, min, modulo, integer divide and (optionally) Euclidean GCD. Operands are captured through a start/ready handshake. Modulo and divide run as an iterative restoring divider, one quotient bit per cycle. The block sits between the datapath sequencer and the result register file; results are flagged by a one-cycle valid pulse.

Parameters:
WIDTH, 16, operand/result width in bits (>= 2)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
start_i  in  1  request; accepted on a rising edge where start_i & ready_o
alu_mode_i  in  3  operation select, sampled only at accept
op_a_i  in  WIDTH  operand A / dividend, unsigned, sampled at accept
op_b_i  in  WIDTH  operand B / divisor, unsigned, sampled at accept
ready_o  out  1  high when idle and able to accept
res_o  out  WIDTH  result; held stable until the next completion
valid_o  out  1  one-cycle pulse, res_o/err_o valid
err_o  out  1  divide-by-zero flag for the current result

Behaviour:
- Reset (rst low, async): state=S_IDLE, res_o=0, valid_o=0, err_o=0, ready_o=1, internal registers 0. Applies mid-operation; the in-flight op is dropped with no valid_o.
- Mode encoding: 0 MAX, 1 MIN, 2 MOD, 3 DIV, 4 GCD; 5-7 are unknown modes.
- States: S_IDLE, S_DIV, S_GCD. ready_o = (state==S_IDLE). This includes the cycle valid_o is high, so back-to-back accepts are legal.
- Single-cycle ops complete at the accepting edge; valid_o is high the next cycle and the state stays S_IDLE:
  - MAX: res = (a>b)?a:b.
  - MIN: res = (a<b)?a:b.
  - Unknown mode: res=0, err=0.
  - MOD/DIV with b==0: res=0, err=1.
  - GCD with b==0: res=a, err=0.
- MOD/DIV with b!=0:
  - Accept: load q=a, r=0 (WIDTH+1 bits), cnt=WIDTH; go to S_DIV.
  - Each S_DIV edge: r={r[WIDTH-1:0],q[WIDTH-1]}; q=q<<1; if r>=b then r=r-b, q[0]=1; cnt=cnt-1.
  - On the edge where cnt reaches 0: res_o=r (MOD) or q (DIV), err_o=0, valid_o=1 next cycle, go to S_IDLE.
  - Latency: WIDTH edges from accept to result. ready_o is low for WIDTH cycles.
- GCD (b!=0): Euclid built on the same divider.
  - Enter S_GCD with x=a, y=b and run x mod y (WIDTH cycles).
  - On completion, if rem==0: res_o=y, complete. Otherwise x=y, y=rem, restart the divider on the same edge.
  - Latency: WIDTH × (number of mod steps).
- While busy, start_i, alu_mode_i and operands are ignored. valid_o is never asserted without a prior accept.
- All arithmetic is unsigned and results never exceed WIDTH bits. The remainder register is WIDTH+1 bits so the compare cannot overflow.

Optional Feature:
SEQ_ALU_GCD_EN:
- Defined: mode 4 performs GCD as above and S_GCD exists.
- Undefined: mode 4 is treated as an unknown mode (res 0, err 0, single-cycle) and S_GCD logic is not built.

Decomposition:
- Package alu_pkg holds:
  - Mode localparams ALU_MAX, ALU_MIN, ALU_MOD, ALU_DIV, ALU_GCD (3 bits).
  - State encoding typedef alu_state_t (S_IDLE, S_DIV, S_GCD).
- Sub-module alu_div_step: combinational single restoring-division iteration.
  - Parametrised by WIDTH.
  - Inputs r, q, divisor; outputs next r, next q.
  - Instantiated once in seq_alu and shared by MOD/DIV/GCD.

Test Plan:
- MAX a=7, b=300 -> res_o=300, valid_o the cycle after accept, ready_o stays 1. MIN with the same operands -> 7. Mode 6 -> res 0, err 0.
- MOD a=1000, b=7 -> res_o=6, err 0, valid_o 16 cycles after accept, ready_o low for 16 cycles. DIV with the same operands -> 142. DIV a=65535, b=1 -> 65535.
- MOD a=5, b=0 -> res_o=0, err_o=1, single-cycle.
- GCD a=48, b=18 with SEQ_ALU_GCD_EN -> res_o=6 after 48 cycles. GCD a=0, b=5 -> 5. Macro undefined: mode 4 -> 0 in 1 cycle.
- Reset asserted 5 cycles into a DIV -> res_o=0, valid_o never pulses, ready_o=1. After release, MOD 100,9 -> 1.
- start_i held high with changing operands during a MOD -> ignored. New request accepted in the valid_o cycle -> its result follows with the correct latency.
